// File: rtl/dot_pipe.sv
// Three-stage pipelined signed fixed-point dot product between two FIFOs.
// S1 holds scaled products, S2 their sum, S3 the converted result and overflow flag.
module dot_pipe #(
  parameter int N_ELEM     = 3,
  parameter int DATA_WIDTH = 32,
  parameter int Q_BITS     = 10,
  parameter int ROUND      = 0,
  parameter int SATURATE   = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic signed [DATA_WIDTH-1:0] x [N_ELEM-1:0],
  input  logic signed [DATA_WIDTH-1:0] y [N_ELEM-1:0],
  input  logic                         in_empty,
  output logic                         in_rd_en,
  output logic signed [DATA_WIDTH-1:0] out,
  output logic                         out_ovf,
  input  logic                         out_full,
  output logic                         out_wr_en,
  output logic                         busy
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int SW = PW + $clog2(N_ELEM) + 1;

  localparam logic signed [PW-1:0] RND_C =
    (ROUND != 0 && Q_BITS > 0) ? (PW'(1) << (Q_BITS > 0 ? Q_BITS - 1 : 0)) : '0;
  localparam logic signed [SW-1:0] MAX_V = {{(SW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] MIN_V = ~MAX_V;

  logic                         advance;
  logic                         v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic signed [PW-1:0]         prod_c [N_ELEM];
  logic signed [PW-1:0]         prod_q [N_ELEM];
  logic signed [PW-1:0]         prod_d [N_ELEM];
  logic signed [SW-1:0]         sum_c, sum_q, sum_d;
  logic signed [DATA_WIDTH-1:0] res_c, res_q, res_d;
  logic                         ovf_c, ovf_q, ovf_d;

  // Products are exact at 2*DATA_WIDTH; the rounding offset cannot overflow that width.
  generate
    for (genvar gi = 0; gi < N_ELEM; gi++) begin : g_prod
      logic signed [PW-1:0] xe, ye, pr;
      assign xe         = x[gi];
      assign ye         = y[gi];
      assign pr         = xe * ye + RND_C;
      assign prod_c[gi] = pr >>> Q_BITS;
    end
  endgenerate

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < N_ELEM; i++) begin
      sum_c = sum_c + SW'(prod_q[i]);
    end
  end

  always_comb begin
    ovf_c = (sum_q > MAX_V) || (sum_q < MIN_V);
    res_c = sum_q[DATA_WIDTH-1:0];
    if (SATURATE != 0 && ovf_c) begin
      res_c = (sum_q > MAX_V) ? MAX_V[DATA_WIDTH-1:0] : MIN_V[DATA_WIDTH-1:0];
    end
  end

  always_comb begin
    advance   = !(v3_q && out_full);
    in_rd_en  = !reset && !in_empty && advance;
    out_wr_en = !reset && v3_q && !out_full;

    v1_d   = v1_q;
    v2_d   = v2_q;
    v3_d   = v3_q;
    prod_d = prod_q;
    sum_d  = sum_q;
    res_d  = res_q;
    ovf_d  = ovf_q;

    // Whole pipeline moves together; a full downstream FIFO with S3 valid freezes everything.
    if (advance) begin
      v1_d = in_rd_en;
      v2_d = v1_q;
      v3_d = v2_q;
      if (in_rd_en) prod_d = prod_c;
      if (v1_q)     sum_d  = sum_c;
      if (v2_q) begin
        res_d = res_c;
        ovf_d = ovf_c;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      prod_q <= '{default: '0};
      sum_q  <= '0;
      res_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      v3_q   <= v3_d;
      prod_q <= prod_d;
      sum_q  <= sum_d;
      res_q  <= res_d;
      ovf_q  <= ovf_d;
    end
  end

  assign out     = res_q;
  assign out_ovf = ovf_q;
  assign busy    = v1_q || v2_q || v3_q;

endmodule

// File: doc/dot_pipe.md
Name: dot_pipe

Overview:
Parametrised, fully pipelined signed fixed-point dot product engine. Consumes one N_ELEM-wide vector pair per cycle from an upstream FIFO (empty/rd_en handshake) and pushes one scalar result per cycle into a downstream FIFO (full/wr_en handshake).
Successor to the current 3-element, 2-cycle-per-result dot unit. Adds configurable element count, width and Q format, optional rounding, saturation with overflow flag, and stall-safe backpressure at full throughput.

Parameters:
N_ELEM, 3, number of vector elements (>=1)
DATA_WIDTH, 32, width of each signed input element and of the result
Q_BITS, 10, fractional bits of the fixed-point format (0 <= Q_BITS < DATA_WIDTH)
ROUND, 0, 1 = round-half-up before shift; 0 = arithmetic shift (floor)
SATURATE, 1, 1 = clamp result to DATA_WIDTH signed range; 0 = wrap (keep low DATA_WIDTH bits)

Ports:
clock  in  1  single clock; all logic on posedge
reset  in  1  synchronous, active-high
x  in  N_ELEM x DATA_WIDTH signed (unpacked [N_ELEM-1:0])  operand vector A
y  in  N_ELEM x DATA_WIDTH signed (unpacked [N_ELEM-1:0])  operand vector B
in_empty  in  1  upstream FIFO empty
in_rd_en  out  1  pop upstream; x/y sampled this cycle
out  out  DATA_WIDTH signed  result, valid while out_wr_en=1
out_ovf  out  1  result exceeded signed DATA_WIDTH range (sideband of out)
out_full  in  1  downstream FIFO full
out_wr_en  out  1  push out/out_ovf downstream
busy  out  1  any pipeline stage holds a valid entry

Behaviour:
- Pipeline has three registered stages, each with a valid bit: S1 products, S2 sum, S3 result+ovf.
- Stall rule: advance = !(v3 && out_full). When advance=0, every stage and every valid bit holds.
- in_rd_en = !reset && !in_empty && advance (combinational). x/y are captured into S1 only when in_rd_en=1.
- out_wr_en = v3 && !out_full (combinational). out and out_ovf are driven directly from S3 registers.
- Latency: vector popped in cycle T -> out_wr_en=1 in cycle T+3 when there is no stall. Throughput is 1 result/cycle. Results stay strictly in order; none is dropped or duplicated.
- Bubbles (in_empty=1) propagate as valid=0. A bubble does not stall upstream stages.
- Arithmetic per element: p_i = x_i*y_i at full 2*DATA_WIDTH signed.
  - ROUND=1: p_i += 2^(Q_BITS-1) when Q_BITS>0.
  - Then arithmetic shift right by Q_BITS.
- Sum: s = sum of shifted p_i, at width 2*DATA_WIDTH + clog2(N_ELEM)+1. This width cannot overflow internally.
- Output conversion:
  - ovf = (s > 2^(DATA_WIDTH-1)-1) || (s < -2^(DATA_WIDTH-1)).
  - SATURATE=1: out = clamped s.
  - SATURATE=0: out = s[DATA_WIDTH-1:0].
  - out_ovf = ovf in both modes.
- Reset (synchronous, may occur mid-operation):
  - All valid bits clear; in-flight data is discarded and never written.
  - out=0, out_ovf=0, busy=0.
  - in_rd_en=0 and out_wr_en=0 while reset=1.
  - First pop is possible in the cycle after reset deasserts.
- Simultaneous in_empty=0 and stall: no pop; the upstream vector stays in its FIFO.
- out_full asserted with v3=0: no stall, so the pipeline fills until S3 is valid.

Test Plan:
1. Defaults. x={1024,2048,3072}, y={1024,1024,1024}, popped at T -> out_wr_en=1 at T+3, out=6144, out_ovf=0.
2. Rounding with N_ELEM=1, x={-1}, y={512}.
   - ROUND=0 -> out=-1 (0xFFFFFFFF).
   - ROUND=1 -> out=0.
   - x={3}, y={512}, ROUND=1 -> out=2 (1.5 rounds up).
3. Overflow. All x_i=y_i=0x7FFFFFFF.
   - SATURATE=1 -> out=0x7FFFFFFF, out_ovf=1.
   - SATURATE=0 -> out=0xFF400000, out_ovf=1.
   - All x_i=0x80000000 with y_i=0x7FFFFFFF, SATURATE=1 -> out=0x80000000, out_ovf=1.
4. Streaming. Upstream holds 8 vectors with in_empty=0 continuously.
   - in_rd_en is high for 8 consecutive cycles.
   - out_wr_en is high for 8 consecutive cycles starting 3 cycles after the first pop.
   - Results match the golden model in order.
5. Backpressure. During a 16-vector stream, hold out_full=1 for 5 cycles once v3=1.
   - in_rd_en=0 and out_wr_en=0 for those cycles; out stays stable.
   - After release, all 16 results arrive exactly once, in order.
6. Mid-stream reset. Assert reset for 1 cycle with 3 vectors in flight.
   - Next cycle: busy=0, out=0, out_ovf=0, no out_wr_en from the discarded entries.
   - A new vector popped after reset produces the correct result at +3.
